// File: rtl/popcount_pkg.sv
// Shared types and elaboration-time helpers for the pipelined population counter.
package popcount_pkg;

  typedef enum logic {
    POP_ONES  = 1'b0,
    POP_ZEROS = 1'b1
  } pop_mode_e;

  function automatic int unsigned tree_levels(input int unsigned width);
    return (width <= 1) ? 0 : $clog2(width);
  endfunction

  function automatic int unsigned calc_latency(input int unsigned width,
                                               input int unsigned lps);
    int unsigned tl;
    int unsigned lat;
    tl  = tree_levels(width);
    lat = (tl + lps - 1) / lps;
    return (lat < 1) ? 1 : lat;
  endfunction

  // Adder levels folded into register slice s; trailing slices may get fewer than lps.
  function automatic int unsigned stage_levels(input int unsigned width,
                                               input int unsigned lps,
                                               input int unsigned s);
    int unsigned tl;
    int unsigned lo;
    tl = tree_levels(width);
    lo = s * lps;
    if (lo >= tl) return 0;
    return ((tl - lo) < lps) ? (tl - lo) : lps;
  endfunction

endpackage

// File: rtl/popcount_pipelined_stage.sv
// One register slice: NLEV pairwise-add levels over IN_N operands of IN_W bits,
// then a valid/ready-qualified output register.
module popcount_stage #(
  parameter int unsigned IN_N = 16,
  parameter int unsigned IN_W = 1,
  parameter int unsigned NLEV = 2
) (
  input  logic                                      clk_i,
  input  logic                                      arst_n_i,
  input  logic [IN_N*IN_W-1:0]                      in_data_i,
  input  logic                                      in_val_i,
  output logic                                      in_rdy_o,
  output logic [(IN_N>>NLEV)*(IN_W+NLEV)-1:0]       out_data_o,
  output logic                                      out_val_o,
  input  logic                                      out_rdy_i
);

  localparam int unsigned OUT_N = IN_N >> NLEV;
  localparam int unsigned OUT_W = IN_W + NLEV;

  logic [OUT_W-1:0]         lvl [NLEV+1][IN_N];
  logic [OUT_N*OUT_W-1:0]   sum;
  logic [OUT_N*OUT_W-1:0]   data_d, data_q;
  logic                     valid_d, valid_q;

  // All levels share the final operand width, so no partial sum is ever truncated.
  always_comb begin
    for (int unsigned l = 0; l <= NLEV; l++) begin
      for (int unsigned i = 0; i < IN_N; i++) begin
        lvl[l][i] = '0;
      end
    end
    for (int unsigned i = 0; i < IN_N; i++) begin
      lvl[0][i] = OUT_W'(in_data_i[i*IN_W +: IN_W]);
    end
    for (int unsigned l = 0; l < NLEV; l++) begin
      for (int unsigned i = 0; i < (IN_N >> (l + 1)); i++) begin
        lvl[l+1][i] = lvl[l][2*i] + lvl[l][2*i+1];
      end
    end
    sum = '0;
    for (int unsigned i = 0; i < OUT_N; i++) begin
      sum[i*OUT_W +: OUT_W] = lvl[NLEV][i];
    end
  end

  assign in_rdy_o = !valid_q || out_rdy_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_rdy_o) begin
      valid_d = in_val_i;
      if (in_val_i) data_d = sum;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_data_o = data_q;
  assign out_val_o  = valid_q;

endmodule

// File: rtl/popcount_pipelined.sv
// Pipelined population counter: optional inversion, power-of-two padding, then a
// chain of register slices each folding LEVELS_PER_STAGE adder-tree levels.
module popcount_pipelined
  import popcount_pkg::*;
#(
  parameter int unsigned WIDTH            = 16,
  parameter int unsigned LEVELS_PER_STAGE = 2
) (
  input  logic                         clk_i,
  input  logic                         arst_n_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         mode_i,
  input  logic                         data_val_i,
  output logic                         data_rdy_o,
  output logic [$clog2(WIDTH+1)-1:0]   cnt_o,
  output logic                         cnt_val_o,
  input  logic                         cnt_rdy_i
);

  localparam int unsigned CNT_W       = $clog2(WIDTH + 1);
  localparam int unsigned TREE_LEVELS = tree_levels(WIDTH);
  localparam int unsigned PAD_W       = 1 << TREE_LEVELS;
  localparam int unsigned LATENCY     = calc_latency(WIDTH, LEVELS_PER_STAGE);

  pop_mode_e          mode;
  logic [PAD_W-1:0]   data_pad;
  logic [LATENCY:0]   vld;
  logic [LATENCY:0]   rdy;

  assign mode = pop_mode_e'(mode_i);

  // Pad bits are zeroed after inversion so zeros mode never counts them.
  always_comb begin
    data_pad              = '0;
    data_pad[WIDTH-1:0]   = (mode == POP_ZEROS) ? ~data_i : data_i;
  end

  assign vld[0]       = data_val_i;
  assign data_rdy_o   = rdy[0];
  assign rdy[LATENCY] = cnt_rdy_i;
  assign cnt_val_o    = vld[LATENCY];

  for (genvar s = 0; s < LATENCY; s++) begin : g_stage
    localparam int unsigned LO    = s * LEVELS_PER_STAGE;
    localparam int unsigned IN_W  = LO + 1;
    localparam int unsigned IN_N  = PAD_W >> LO;
    localparam int unsigned NLEV  = stage_levels(WIDTH, LEVELS_PER_STAGE, s);
    localparam int unsigned OUT_W = IN_W + NLEV;
    localparam int unsigned OUT_N = IN_N >> NLEV;

    logic [IN_N*IN_W-1:0]   in_d;
    logic [OUT_N*OUT_W-1:0] out_d;

    if (s == 0) begin : g_first
      assign in_d = data_pad;
    end else begin : g_chain
      assign in_d = g_stage[s-1].out_d;
    end

    popcount_stage #(
      .IN_N (IN_N),
      .IN_W (IN_W),
      .NLEV (NLEV)
    ) u_stage (
      .clk_i      (clk_i),
      .arst_n_i   (arst_n_i),
      .in_data_i  (in_d),
      .in_val_i   (vld[s]),
      .in_rdy_o   (rdy[s]),
      .out_data_o (out_d),
      .out_val_o  (vld[s+1]),
      .out_rdy_i  (rdy[s+1])
    );
  end

  // Final slice is TREE_LEVELS+1 bits wide; the count never exceeds WIDTH.
  assign cnt_o = CNT_W'(g_stage[LATENCY-1].out_d);

endmodule

// File: tb/tb_popcount_pipelined.sv
// Scoreboarded bench: a 16-bit main instance with directed and backpressure
// traffic, plus a width/levels sweep of independent instances.
module tb_popcount_pipelined;
  import popcount_pkg::*;

  localparam int unsigned LAT0 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n    = 1'b0;
  logic rst_sw_n = 1'b0;
  int   errors   = 0;
  int   checks   = 0;
  int   sw_done  = 0;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int unsigned cfg_w(input int i);
    case (i)
      0: return 13;
      1: return 1;
      2: return 1;
      3: return 7;
      4: return 7;
      5: return 64;
      default: return 64;
    endcase
  endfunction

  function automatic int unsigned cfg_l(input int i);
    case (i)
      0: return 2;
      1: return 1;
      2: return 3;
      3: return 1;
      4: return 3;
      5: return 1;
      default: return 3;
    endcase
  endfunction

  function automatic int unsigned cfg_lat(input int i);
    case (i)
      0: return 2;
      1: return 1;
      2: return 1;
      3: return 3;
      4: return 1;
      5: return 6;
      default: return 2;
    endcase
  endfunction

  // ---------------- main instance: WIDTH=16, LPS=2 ----------------
  logic [15:0] d  = '0;
  logic        m  = 1'b0;
  logic        v  = 1'b0;
  logic        r  = 1'b0;
  logic        dr;
  logic        cv;
  logic [4:0]  c;

  popcount_pipelined #(
    .WIDTH            (16),
    .LEVELS_PER_STAGE (2)
  ) u_dut (
    .clk_i      (clk),
    .arst_n_i   (rst_n),
    .data_i     (d),
    .mode_i     (m),
    .data_val_i (v),
    .data_rdy_o (dr),
    .cnt_o      (c),
    .cnt_val_o  (cv),
    .cnt_rdy_i  (r)
  );

  int unsigned q[$];
  bit          stall_prev = 1'b0;
  logic [4:0]  stall_c    = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      stall_prev = 1'b0;
    end else begin
      chk("data_rdy", dr, (q.size() == LAT0 && !r) ? 0 : 1);
      if (q.size() == 0) chk("idle_valid", cv, 0);
      if (stall_prev) begin
        chk("stall_valid", cv, 1);
        chk("stall_cnt", c, stall_c);
      end
      stall_prev = cv && !r;
      stall_c    = c;
      if (cv && r) begin
        if (q.size() == 0) chk("spurious_out", 1, 0);
        else chk("count", c, q.pop_front());
      end
      if (v && dr) q.push_back($countones(m ? ~d : d));
    end
  end

  initial begin
    int sent;
    int guard;
    bit need_new;

    repeat (3) @(posedge clk);
    #3;
    rst_n    = 1'b1;
    rst_sw_n = 1'b1;
    @(negedge clk);
    chk("reset_valid", cv, 0);
    chk("reset_cnt", c, 0);
    chk("reset_rdy", dr, 1);

    // back-to-back ones-mode words, rdy high
    @(posedge clk); #1;
    r = 1'b1; v = 1'b1; m = 1'b0; d = 16'hFFFF;
    @(posedge clk); #1; d = 16'h0000;
    @(posedge clk); #1; d = 16'h8001;
    @(negedge clk); chk("b2b_first", {cv, c}, {1'b1, 5'd16});
    @(posedge clk); #1; v = 1'b0;
    @(negedge clk); chk("b2b_second", {cv, c}, {1'b1, 5'd0});
    @(posedge clk); #1;
    @(negedge clk); chk("b2b_third", {cv, c}, {1'b1, 5'd2});
    repeat (3) @(posedge clk);
    #1;

    // zeros mode
    v = 1'b1; m = 1'b1; d = 16'h00F0;
    @(posedge clk); #1; v = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk); chk("zeros_00f0", {cv, c}, {1'b1, 5'd12});
    repeat (3) @(posedge clk);

    // random stream under random backpressure
    sent = 0; guard = 0; need_new = 1'b1;
    while (sent < 20 && guard < 1000) begin
      @(posedge clk); #1;
      if (need_new) begin
        d = 16'($urandom);
        m = 1'($urandom);
        need_new = 1'b0;
      end
      v = 1'b1;
      r = 1'($urandom);
      @(negedge clk);
      if (dr) begin
        sent++;
        need_new = 1'b1;
      end
      guard++;
    end
    chk("stream_sent", sent, 20);
    @(posedge clk); #1; v = 1'b0;
    guard = 0;
    while (q.size() != 0 && guard < 200) begin
      r = 1'($urandom);
      @(posedge clk); #1;
      guard++;
    end
    chk("stream_drain", q.size(), 0);

    // fill, then simultaneous drain and accept
    r = 1'b0; v = 1'b1; d = 16'($urandom); m = 1'($urandom);
    @(negedge clk); chk("fill_a_rdy", dr, 1);
    @(posedge clk); #1; d = 16'($urandom);
    @(negedge clk); chk("fill_b_rdy", dr, 1);
    @(posedge clk); #1; d = 16'($urandom);
    @(negedge clk); chk("full_blocked", dr, 0);
    @(posedge clk); #1; r = 1'b1;
    @(negedge clk);
    chk("full_swap_rdy", dr, 1);
    chk("full_swap_val", cv, 1);
    @(posedge clk); #1; v = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // reset with two words in flight
    r = 1'b0; v = 1'b1; d = 16'($urandom);
    @(posedge clk); #1; d = 16'($urandom);
    @(posedge clk); #1; v = 1'b0;
    @(negedge clk); chk("inflight_val", cv, 1);
    #2; rst_n = 1'b0;
    #1;
    chk("rst_drop_val", cv, 0);
    chk("rst_drop_cnt", c, 0);
    repeat (2) @(posedge clk);
    #3; rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_idle", cv, 0);
    end

    guard = 0;
    while (sw_done < 7 && guard < 20000) begin
      @(posedge clk);
      guard++;
    end
    chk("sweep_done", sw_done, 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- sweep instances ----------------
  for (genvar g = 0; g < 7; g++) begin : g_sw
    localparam int unsigned W   = cfg_w(g);
    localparam int unsigned L   = cfg_l(g);
    localparam int unsigned LAT = cfg_lat(g);
    localparam int unsigned CW  = $clog2(W + 1);

    logic [W-1:0]  sd  = '0;
    logic          sm  = 1'b0;
    logic          sv  = 1'b0;
    logic          sr  = 1'b0;
    logic          sdr;
    logic          scv;
    logic [CW-1:0] sc;
    int unsigned   sq[$];

    popcount_pipelined #(
      .WIDTH            (W),
      .LEVELS_PER_STAGE (L)
    ) u_dut (
      .clk_i      (clk),
      .arst_n_i   (rst_sw_n),
      .data_i     (sd),
      .mode_i     (sm),
      .data_val_i (sv),
      .data_rdy_o (sdr),
      .cnt_o      (sc),
      .cnt_val_o  (scv),
      .cnt_rdy_i  (sr)
    );

    always @(negedge clk) begin
      if (rst_sw_n) begin
        chk($sformatf("sw%0d_rdy", g), sdr, (sq.size() == LAT && !sr) ? 0 : 1);
        if (sq.size() == 0) chk($sformatf("sw%0d_idle", g), scv, 0);
        if (scv && sr) begin
          if (sq.size() == 0) chk($sformatf("sw%0d_spurious", g), 1, 0);
          else chk($sformatf("sw%0d_count", g), sc, sq.pop_front());
        end
        if (sv && sdr) sq.push_back($countones(sm ? ~sd : sd));
      end
    end

    initial begin
      longint unsigned tmp;
      int lat_meas;
      int sent;
      int guard;
      bit need_new;

      @(posedge rst_sw_n);
      @(posedge clk); #1;
      sr = 1'b1; sv = 1'b1; sm = 1'b1; sd = '0;
      @(posedge clk); #1;
      sv = 1'b0;
      lat_meas = 1;
      @(negedge clk);
      while (!scv && lat_meas < 20) begin
        @(posedge clk); #1;
        lat_meas++;
        @(negedge clk);
      end
      chk($sformatf("sw%0d_latency", g), lat_meas, LAT);
      chk($sformatf("sw%0d_latency_pkg", g), lat_meas, calc_latency(W, L));
      chk($sformatf("sw%0d_zero_word", g), sc, W);

      sent = 0; guard = 0; need_new = 1'b1;
      while (sent < 30 && guard < 1500) begin
        @(posedge clk); #1;
        if (need_new) begin
          tmp = {$urandom, $urandom};
          sd  = tmp[W-1:0];
          sm  = 1'($urandom);
          need_new = 1'b0;
        end
        sv = 1'b1;
        sr = 1'($urandom);
        @(negedge clk);
        if (sdr) begin
          sent++;
          need_new = 1'b1;
        end
        guard++;
      end
      chk($sformatf("sw%0d_sent", g), sent, 30);
      @(posedge clk); #1; sv = 1'b0;
      guard = 0;
      while (sq.size() != 0 && guard < 300) begin
        sr = 1'($urandom);
        @(posedge clk); #1;
        guard++;
      end
      chk($sformatf("sw%0d_drain", g), sq.size(), 0);
      sw_done++;
    end
  end

endmodule

// File: doc/popcount_pipelined.md
POPCOUNT_PIPELINED -- requirements
Module: popcount_pipelined

Interface
REQ-001 Parameter WIDTH, default 16: input word width in bits, legal range 1..1024.
REQ-002 Parameter LEVELS_PER_STAGE, default 2: adder-tree levels between pipeline registers, legal range >= 1.
REQ-003 Derived constants: CNT_W = $clog2(WIDTH+1); TREE_LEVELS = $clog2(WIDTH) (0 when WIDTH=1); LATENCY = max(1, ceil(TREE_LEVELS/LEVELS_PER_STAGE)).
REQ-004 Port clk_i  input  1  sole clock, all state on rising edge.
REQ-005 Port arst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-006 Port data_i  input  WIDTH  word to count.
REQ-007 Port mode_i  input  1  0 = count ones, 1 = count zeros; sampled with data_i.
REQ-008 Port data_val_i  input  1  data_i/mode_i valid.
REQ-009 Port data_rdy_o  output  1  block accepts a word this cycle.
REQ-010 Port cnt_o  output  CNT_W  population count result.
REQ-011 Port cnt_val_o  output  1  cnt_o valid.
REQ-012 Port cnt_rdy_i  input  1  downstream accepts cnt_o.

Function
REQ-013 A word transfers in when data_val_i & data_rdy_o on a rising edge; a result transfers out when cnt_val_o & cnt_rdy_i.
REQ-014 Zeros mode inverts data_i before counting; pad bits up to the next power of two are forced to 0 after inversion and never counted.
REQ-015 Count range 0..WIDTH inclusive; each tree level widens operands by 1 bit with no truncation before the final CNT_W result.
REQ-016 With cnt_rdy_i held high, a word accepted on edge N produces cnt_val_o=1 with its count after edge N+LATENCY-1, i.e. LATENCY cycles of register delay.
REQ-017 Each stage holds a valid bit; a stage loads when it is empty or its contents advance in the same cycle; otherwise it holds data and valid.
REQ-018 data_rdy_o = first-stage-empty OR first-stage-advancing; combinational from cnt_rdy_i through the stage valid chain, with no path from data_val_i.
REQ-019 Sustained throughput one word per cycle with data_val_i=cnt_rdy_i=1; no bubbles inserted.
REQ-020 When the pipeline is full and cnt_rdy_i=0, data_rdy_o=0; cnt_o and cnt_val_o hold stable until accepted.
REQ-021 Full pipeline with simultaneous output accept and input valid accepts the new word in the same cycle.
REQ-022 Results leave in acceptance order; none dropped or duplicated under any ready/valid pattern.
REQ-023 WIDTH=1: cnt_o is data_i^mode_i, LATENCY=1.

Reset
REQ-024 arst_n_i low asynchronously clears all stage valid bits: cnt_val_o=0, cnt_o=0, data_rdy_o=1 on the first edge after release.
REQ-025 Reset mid-operation discards all in-flight words; no stale result appears after release.
REQ-026 Datapath registers also reset to 0.

Structure
REQ-027 Package popcount_pkg holds: mode typedef enum (POP_ONES, POP_ZEROS); a function computing LATENCY from WIDTH and LEVELS_PER_STAGE.
REQ-028 Sub-module popcount_stage is one register slice. It takes a vector of partial sums plus a valid/ready pair. It performs up to LEVELS_PER_STAGE pairwise-add levels and registers the result. It is instantiated LATENCY times by generate.

Verification
REQ-029 WIDTH=16, LPS=2, ones mode, data 16'hFFFF, 16'h0000, 16'h8001 back-to-back, rdy=1 -> cnt_o 16, 0, 2 on three consecutive cycles starting 2 cycles after the first accept.
REQ-030 Zeros mode: data 16'h00F0 -> cnt_o=12; WIDTH=13, data 13'h0, zeros mode -> cnt_o=13, not 16.
REQ-031 Backpressure: stream 1..20 random words, cnt_rdy_i random 50% -> scoreboard matches in order, cnt_o stable while stalled, data_rdy_o=0 only when both stages full and cnt_rdy_i=0.
REQ-032 Full pipeline, then cnt_rdy_i=1 with data_val_i=1 same cycle -> one result out and one word in on that edge.
REQ-033 Assert arst_n_i with 2 words in flight -> cnt_val_o drops immediately; after release with no input, cnt_val_o stays 0.
REQ-034 Sweep WIDTH in {1, 7, 64} and LPS in {1, 3} -> latency equals the package function and counts match the reference model.
